pe_packet_receiver: RTL and testbench
=====================================

# pe_packet_receiver

PE-side endpoint of the control-unit packet protocol. It accepts routed output packets that have reached their destination, stores filter rows, and presents one ifmap window at a time to the PE datapath. After the PE consumes each window, it returns an ack packet in the control-unit input-ack format. It sits between the NoC router local port and the PE compute core.

## Interface
- FILTER_WIDTH, 8, bits per filter element; packet data field is 5*FILTER_WIDTH bits.
- PE_NODE, 0, 4-bit node ID placed in ack packets.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  inbound packet valid.
- in_ready  out  1  inbound packet accepted on a clk edge where in_valid && in_ready.
- in_data  in  5*FILTER_WIDTH+13  fields: data [5FW+12:13], filter_row [12:10], type [9] (0 = ifmap, 1 = filter), timestep [8], y-hop [7:5], x-hop [4:2], direction [1:0].
- win_valid  out  1  ifmap window valid to PE.
- win_ready  in  1  PE consumes the window.
- win_data  out  25  ifmap spikes, in_data[5FW+12:5FW-12].
- win_loc  out  5*FILTER_WIDTH-27  conv location, in_data[5FW-13:15].
- win_ts  out  1  timestep of the window.
- filt_size  out  2  size code latched from the last ifmap packet, in_data[14:13]; K = filt_size+2.
- filt_q  out  25*FILTER_WIDTH  filter rows 0..4; row r occupies [(r+1)*5FW-1 : r*5FW].
- ack_valid  out  1  ack packet valid.
- ack_ready  in  1  ack accepted.
- ack_data  out  5*FILTER_WIDTH+5  bits [4:1] = PE_NODE, bit [0] = 0, all other bits 0.
- err  out  3  sticky error flags: [0] filter_row > 4; [1] rows missing at first ifmap after a filter load; [2] nonzero hop/dir (macro only).

## Operation
- FSM states:
  - LOAD_FILT (reset state), RUN, HOLD, ACK.
  - in_ready = 1 in LOAD_FILT and RUN, and 0 in HOLD and ACK.
- Filter packet accepted in LOAD_FILT or RUN:
  - Writes data into row filter_row and sets row_mask[filter_row]. State does not change.
  - If filter_row > 4, the packet is dropped and err[0] is set.
- Ifmap packet accepted in LOAD_FILT or RUN:
  - Latches win_data, win_loc, win_ts and filt_size, then goes to HOLD.
  - If K = in_data[14:13]+2 and any row < K is not set in row_mask, err[1] is set. The window is still presented.
  - row_mask is then cleared, so the next filter packet begins a new load.
- HOLD: win_valid = 1. When win_ready is high, go to ACK.
- ACK: ack_valid = 1. When ack_ready is high, go to RUN.
- Exactly one ack is sent per ifmap window consumed. No ack is sent for filter packets.
- filt_q always reflects the filter storage and is not gated by the FSM.

## Timing
- Reset values:
  - state LOAD_FILT; in_ready 1 (combinational from state).
  - win_valid 0, ack_valid 0, err 0, filt_q 0, filt_size 0, win_* 0, row_mask 0.
- ack_data is constant.
- Inbound ifmap accepted at edge N: win_valid is 1 from edge N.
- Window handshake at edge M: win_valid is 0 and ack_valid is 1 from edge M.
- Ack handshake at edge P: in_ready is 1 from edge P.
- Minimum window-to-window throughput is 3 cycles.
- win_* and ack_valid are held stable while valid is high and ready is low.
- A filter write at edge N is visible on filt_q after edge N.
- Reset asserted mid-operation: any pending window or ack is discarded, filter storage is cleared, and the FSM returns to LOAD_FILT immediately.

## Configuration
- PE_PKT_HOP_CHECK_EN:
  - Defined: an accepted packet with nonzero in_data[7:0] is consumed and dropped with no state change, and err[2] is set.
  - Undefined: bits [7:0] are ignored and err[2] is tied to 0.

## Test plan
- Reset, then filter rows 0,1,2 with data 0x0102030405, 0x0A.., 0x14..; then an ifmap with size 1, data 0x1FFFFFF, loc 7:
  - filt_q rows 0–2 match the written data.
  - win_valid rises on the accept edge with win_data = 0x1FFFFFF, win_loc = 7.
  - err = 0.
- Hold win_ready = 0 for 5 cycles:
  - win_* stay stable and in_ready stays 0.
  - Raise win_ready: ack_valid = 1 with ack_data[4:1] = PE_NODE (set to 9).
- Hold ack_ready = 0 while a second ifmap is offered:
  - The ifmap is not accepted.
  - After ack_ready = 1, the ifmap is accepted on the following edge.
- Filter row 6:
  - err[0] = 1 and filt_q is unchanged.
- Only rows 0,1 loaded, then an ifmap with size 1 (K = 3):
  - err[1] = 1 and the window is still presented.
- With the macro defined, a filter packet with x-hop = 2:
  - The packet is dropped and err[2] = 1.
  - Without the macro, the row is written normally.

Source files
------------

// File: rtl/pe_packet_receiver_if.sv
// pe_packet_receiver_if: inbound packet, ifmap window and ack handshake bundle
interface pe_packet_receiver_if #(
  parameter int FILTER_WIDTH = 8
);
  localparam int DW = 5 * FILTER_WIDTH;
  logic            in_valid;
  logic            in_ready;
  logic [DW+12:0]  in_data;
  logic            win_valid;
  logic            win_ready;
  logic [24:0]     win_data;
  logic [DW-28:0]  win_loc;
  logic            win_ts;
  logic            ack_valid;
  logic            ack_ready;
  logic [DW+4:0]   ack_data;
  modport master (
    output in_valid, in_data, win_ready, ack_ready,
    input  in_ready, win_valid, win_data, win_loc, win_ts, ack_valid, ack_data
  );
  modport slave (
    input  in_valid, in_data, win_ready, ack_ready,
    output in_ready, win_valid, win_data, win_loc, win_ts, ack_valid, ack_data
  );
endinterface

// File: rtl/pe_packet_receiver.sv
// pe_packet_receiver: PE endpoint storing filter rows, presenting ifmap windows, returning acks; PE_PKT_HOP_CHECK_EN drops packets with nonzero hop/dir
module pe_packet_receiver #(
  parameter int         FILTER_WIDTH = 8,
  parameter logic [3:0] PE_NODE      = 4'd0
) (
  input  logic                        clk,
  input  logic                        rst,
  pe_packet_receiver_if.slave         bus,
  output logic [1:0]                  filt_size,
  output logic [25*FILTER_WIDTH-1:0]  filt_q,
  output logic [2:0]                  err
);
  localparam int DW = 5 * FILTER_WIDTH;
  typedef enum logic [1:0] {LOAD_FILT, RUN, HOLD, ACK} state_t;
  state_t                      state_q, state_d;
  logic [4:0]                  mask_q;
  logic [24:0]                 wd_q;
  logic [DW-28:0]              wl_q;
  logic                        wt_q;
  logic [1:0]                  sz_q;
  logic [25*FILTER_WIDTH-1:0]  rows_q;
  logic [2:0]                  err_q;
  logic                        acc, is_filt, hop_bad, miss;
  logic [2:0]                  row;
  logic [1:0]                  in_sz;
  logic [4:0]                  need;
  assign acc     = bus.in_valid && bus.in_ready;
  assign is_filt = bus.in_data[9];
  assign row     = bus.in_data[12:10];
  assign in_sz   = bus.in_data[14:13];
`ifdef PE_PKT_HOP_CHECK_EN
  assign hop_bad = |bus.in_data[7:0];
`else
  logic unused_hop;
  assign unused_hop = ^bus.in_data[7:0];
  assign hop_bad    = 1'b0;
`endif
  assign need = in_sz == 2'd0 ? 5'b00011 : in_sz == 2'd1 ? 5'b00111 : in_sz == 2'd2 ? 5'b01111 : 5'b11111;
  assign miss = |(need & ~mask_q);
  assign bus.in_ready  = state_q == LOAD_FILT || state_q == RUN;
  assign bus.win_valid = state_q == HOLD;
  assign bus.ack_valid = state_q == ACK;
  assign bus.win_data  = wd_q;
  assign bus.win_loc   = wl_q;
  assign bus.win_ts    = wt_q;
  assign bus.ack_data  = {{DW{1'b0}}, PE_NODE, 1'b0};
  assign filt_size     = sz_q;
  assign filt_q        = rows_q;
  assign err           = err_q;
  // next state: accepted ifmap opens a window, then window and ack handshakes advance
  always_comb begin
    state_d = state_q;
    if (acc && !is_filt && !hop_bad) state_d = HOLD;
    else if (state_q == HOLD && bus.win_ready) state_d = ACK;
    else if (state_q == ACK && bus.ack_ready) state_d = RUN;
  end
  // state, filter storage, window latches and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_FILT;
      mask_q  <= '0;
      wd_q    <= '0;
      wl_q    <= '0;
      wt_q    <= 1'b0;
      sz_q    <= '0;
      rows_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc && hop_bad) err_q[2] <= 1'b1;
      if (acc && !hop_bad && is_filt) begin
        if (row > 3'd4) err_q[0] <= 1'b1;
        for (int r = 0; r < 5; r++)
          if (row == r[2:0]) begin
            rows_q[r*DW +: DW] <= bus.in_data[DW+12:13];
            mask_q[r]          <= 1'b1;
          end
      end
      if (acc && !hop_bad && !is_filt) begin
        wd_q   <= bus.in_data[DW+12:DW-12];
        wl_q   <= bus.in_data[DW-13:15];
        wt_q   <= bus.in_data[8];
        sz_q   <= in_sz;
        mask_q <= '0;
        if (miss) err_q[1] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pe_packet_receiver.sv
// tb_pe_packet_receiver: directed stimulus checked every cycle against a packet-level model
module tb_pe_packet_receiver;
  localparam int FW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]    filt_size;
  logic [199:0]  filt_q;
  logic [2:0]    err;
  int checks = 0;
  int errors = 0;
  pe_packet_receiver_if #(.FILTER_WIDTH(FW)) bus();
  pe_packet_receiver #(.FILTER_WIDTH(FW), .PE_NODE(4'd9)) dut (
    .clk(clk), .rst(rst), .bus(bus), .filt_size(filt_size), .filt_q(filt_q), .err(err)
  );
  always #5 clk = ~clk;
  // model state: a pending window, a pending ack, the five stored rows
  logic         m_win, m_ack;
  logic [39:0]  m_rows [5];
  logic [4:0]   m_have;
  logic [2:0]   m_err;
  logic [24:0]  m_wd;
  logic [12:0]  m_wl;
  logic         m_wt;
  logic [1:0]   m_sz;
  function automatic logic [52:0] filt_pkt(input int r, input logic [39:0] d);
    logic [2:0] r3 = r[2:0];
    return {d, r3, 1'b1, 1'b0, 8'h00};
  endfunction
  function automatic logic [52:0] ifm_pkt(input logic [24:0] d, input logic [12:0] l, input logic [1:0] s, input logic t);
    return {d, l, s, 3'b000, 1'b0, t, 8'h00};
  endfunction
  function automatic bit rows_missing(input logic [4:0] have, input logic [1:0] s);
    for (int k = 0; k < int'(s) + 2; k++) if (!have[k]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string n, input logic [199:0] a, input logic [199:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_win <= 1'b0; m_ack <= 1'b0; m_err <= '0; m_have <= '0;
      m_wd <= '0; m_wl <= '0; m_wt <= 1'b0; m_sz <= '0;
      for (int i = 0; i < 5; i++) m_rows[i] <= '0;
    end else if (m_win) begin
      if (bus.win_ready) begin m_win <= 1'b0; m_ack <= 1'b1; end
    end else if (m_ack) begin
      if (bus.ack_ready) m_ack <= 1'b0;
    end else if (bus.in_valid) begin
`ifdef PE_PKT_HOP_CHECK_EN
      if (bus.in_data[7:0] != 8'h00) m_err[2] <= 1'b1;
      else
`endif
      if (bus.in_data[9]) begin
        if (bus.in_data[12:10] > 3'd4) m_err[0] <= 1'b1;
        else begin
          m_rows[bus.in_data[12:10]] <= bus.in_data[52:13];
          m_have[bus.in_data[12:10]] <= 1'b1;
        end
      end else begin
        m_win <= 1'b1;
        m_wd <= bus.in_data[52:28];
        m_wl <= bus.in_data[27:15];
        m_sz <= bus.in_data[14:13];
        m_wt <= bus.in_data[8];
        m_have <= '0;
        if (rows_missing(m_have, bus.in_data[14:13])) m_err[1] <= 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", bus.in_ready, !m_win && !m_ack);
      chk("win_valid", bus.win_valid, m_win);
      chk("ack_valid", bus.ack_valid, m_ack);
      chk("filt_q", filt_q, {m_rows[4], m_rows[3], m_rows[2], m_rows[1], m_rows[0]});
      chk("err", err, m_err);
      chk("filt_size", filt_size, m_sz);
      chk("ack_data", bus.ack_data, {40'h0, 4'd9, 1'b0});
      if (m_win) begin
        chk("win_data", bus.win_data, m_wd);
        chk("win_loc", bus.win_loc, m_wl);
        chk("win_ts", bus.win_ts, m_wt);
      end
    end
  end
  task automatic send(input logic [52:0] p);
    bit r = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = p;
    for (int i = 0; i < 30 && !r; i++) begin
      r = bus.in_ready;
      @(negedge clk);
    end
    chk("send_timeout", r, 1'b1);
    bus.in_valid = 1'b0;
  endtask
  task automatic take_win();
    for (int i = 0; i < 30 && !bus.win_valid; i++) @(negedge clk);
    chk("win_timeout", bus.win_valid, 1'b1);
    bus.win_ready = 1'b1;
    @(negedge clk);
    bus.win_ready = 1'b0;
  endtask
  task automatic take_ack();
    for (int i = 0; i < 30 && !bus.ack_valid; i++) @(negedge clk);
    chk("ack_timeout", bus.ack_valid, 1'b1);
    bus.ack_ready = 1'b1;
    @(negedge clk);
    bus.ack_ready = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.win_ready = 1'b0; bus.ack_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_filt_q", filt_q, 200'h0);
    chk("rst_err", err, 3'b000);
    send(filt_pkt(0, 40'h0102030405));
    send(filt_pkt(1, 40'h0A0B0C0D0E));
    send(filt_pkt(2, 40'h1415161718));
    send(ifm_pkt(25'h1FFFFFF, 13'd7, 2'd1, 1'b0));
    chk("t1_filt_q", filt_q, {80'h0, 40'h1415161718, 40'h0A0B0C0D0E, 40'h0102030405});
    chk("t1_win_valid", bus.win_valid, 1'b1);
    chk("t1_win_data", bus.win_data, 25'h1FFFFFF);
    chk("t1_win_loc", bus.win_loc, 13'd7);
    chk("t1_err", err, 3'b000);
    repeat (5) @(negedge clk);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    chk("stall_win_data", bus.win_data, 25'h1FFFFFF);
    take_win();
    chk("ack_valid", bus.ack_valid, 1'b1);
    chk("ack_node", bus.ack_data[4:1], 4'd9);
    bus.in_valid = 1'b1;
    bus.in_data  = ifm_pkt(25'h0ABCDEF, 13'h1234, 2'd3, 1'b1);
    repeat (3) @(negedge clk);
    chk("ack_stall_win", bus.win_valid, 1'b0);
    bus.ack_ready = 1'b1;
    @(negedge clk);
    bus.ack_ready = 1'b0;
    chk("after_ack_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t2_win_valid", bus.win_valid, 1'b1);
    chk("t2_win_data", bus.win_data, 25'h0ABCDEF);
    chk("t2_win_ts", bus.win_ts, 1'b1);
    chk("t2_size", filt_size, 2'd3);
    chk("t2_err1", err[1], 1'b1);
    take_win();
    take_ack();
    send(filt_pkt(6, 40'hFFFFFFFFFF));
    chk("row6_err0", err[0], 1'b1);
    chk("row6_filt_q", filt_q, {80'h0, 40'h1415161718, 40'h0A0B0C0D0E, 40'h0102030405});
    send(filt_pkt(0, 40'h1111111111));
    send(filt_pkt(1, 40'h2222222222));
    send(ifm_pkt(25'h0000001, 13'd3, 2'd1, 1'b0));
    chk("miss_win_valid", bus.win_valid, 1'b1);
    chk("miss_err1", err[1], 1'b1);
    take_win();
    take_ack();
    send(filt_pkt(3, 40'h5555555555) | 53'h08);
`ifdef PE_PKT_HOP_CHECK_EN
    chk("hop_err2", err[2], 1'b1);
    chk("hop_row3", filt_q[159:120], 40'h0);
`else
    chk("hop_err2", err[2], 1'b0);
    chk("hop_row3", filt_q[159:120], 40'h5555555555);
`endif
    send(ifm_pkt(25'h1234567, 13'd9, 2'd0, 1'b0));
    chk("pre_rst_win", bus.win_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_win_valid", bus.win_valid, 1'b0);
    chk("midrst_filt_q", filt_q, 200'h0);
    chk("midrst_win_data", bus.win_data, 25'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst_in_ready", bus.in_ready, 1'b1);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
